// File: rtl/ethernet_transmit.sv
// ethernet_transmit
// Serialises one Ethernet frame per request onto a 4-bit PHY transmit
// interface, two clocks per byte, low nibble first. The frame is preamble,
// SFD, destination MAC, source MAC, EtherType, payload, zero pad and FCS,
// followed by an inter-frame gap.
//
// Ports
//   phy_tx_clk   in   clock for all logic
//   reset_n      in   synchronous active-low reset
//   tx_start     in   one-cycle frame request, taken only while idle
//   tx_len       in   payload byte count, clamped to 1500
//   tx_data      in   payload byte, valid one cycle after tx_data_req
//   tx_data_req  out  one-cycle pulse asking upstream for the next byte
//   busy         out  frame or gap in progress
//   tx_done      out  pulse on the last gap cycle
//   phy_txd      out  transmit nibble
//   phy_tx_ctrl  out  transmit enable
//   status       out  one-hot current state
//
// state     | meaning
// ----------+---------------------------------------------
// IDLE      | waiting for tx_start, line quiet
// PREAMBLE  | 7 bytes of 8'h55
// SFD       | 1 byte of 8'hd5
// DST_MAC   | 6 destination address bytes, MSB first
// SRC_MAC   | 6 source address bytes, MSB first
// TYPE      | 2 EtherType bytes, MSB first
// PAYLOAD   | L upstream bytes
// PAD       | zero bytes up to the 46-byte minimum payload
// FCS       | 4 bytes of inverted CRC, LSB first
// IFG       | line quiet for IFG_BYTES byte times

module ethernet_transmit #(
   parameter logic [47:0] DST_MAC   = 48'hffffffffffff,
   parameter logic [47:0] BOARD_MAC = 48'h000a3501fec0,
   parameter logic [15:0] ETH_TYPE  = 16'h0800,
   parameter int unsigned IFG_BYTES = 12
) (
   input  logic        phy_tx_clk,
   input  logic        reset_n,
   input  logic        tx_start,
   input  logic [10:0] tx_len,
   input  logic [7:0]  tx_data,
   output logic        tx_data_req,
   output logic        busy,
   output logic        tx_done,
   output logic [3:0]  phy_txd,
   output logic        phy_tx_ctrl,
   output logic [9:0]  status
);

   typedef enum logic [9:0] {
      S_IDLE     = 10'b0000000001,
      S_PREAMBLE = 10'b0000000010,
      S_SFD      = 10'b0000000100,
      S_DST      = 10'b0000001000,
      S_SRC      = 10'b0000010000,
      S_TYPE     = 10'b0000100000,
      S_PAYLOAD  = 10'b0001000000,
      S_PAD      = 10'b0010000000,
      S_FCS      = 10'b0100000000,
      S_IFG      = 10'b1000000000
   } state_t;

   localparam logic [10:0] MAX_LEN  = 11'd1500;
   localparam logic [10:0] MIN_LEN  = 11'd46;
   localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);

   state_t      state_q, state_d;
   logic        phase_q, phase_d;
   logic [10:0] cnt_q, cnt_d;
   logic [7:0]  byte_q, byte_d;
   logic [31:0] crc_q, crc_d;
   logic [10:0] len_q, len_d;
   logic [3:0]  txd_q, txd_d;
   logic        ctrl_q, ctrl_d;
   logic        req_q, req_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;

   logic [31:0] crc_upd;
   logic [10:0] len_last;
   logic [10:0] pad_last;

   // Reflected CRC-32, one byte per call.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
      return r;
   endfunction

   // Byte i of a 48-bit address, MSB byte first.
   function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] i);
      logic [47:0] s;
      s = m >> (6'd40 - {i, 3'b000});
      return s[7:0];
   endfunction

   // Byte i of the FCS word, LSB byte first.
   function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] i);
      logic [31:0] s;
      s = ~c >> {i, 3'b000};
      return s[7:0];
   endfunction

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      byte_d   = byte_q;
      crc_d    = crc_q;
      len_d    = len_q;
      crc_upd  = crc_byte(crc_q, byte_q);
      len_last = len_q - 11'd1;
      pad_last = 11'd45 - len_q;

      if (state_q == S_IDLE) begin
         phase_d = 1'b0;
         if (tx_start) begin
            state_d = S_PREAMBLE;
            cnt_d   = '0;
            byte_d  = 8'h55;
            crc_d   = '1;
            len_d   = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
         end
      end else if (!phase_q) begin
         phase_d = 1'b1;
      end else begin
         // End of a byte time: advance to the next byte on the wire.
         phase_d = 1'b0;
         cnt_d   = cnt_q + 11'd1;
         if (state_q inside {S_DST, S_SRC, S_TYPE, S_PAYLOAD, S_PAD})
            crc_d = crc_upd;
         unique case (state_q)
            S_PREAMBLE:
               if (cnt_q == 11'd6) begin
                  state_d = S_SFD;
                  cnt_d   = '0;
                  byte_d  = 8'hd5;
               end else begin
                  byte_d = 8'h55;
               end
            S_SFD: begin
               state_d = S_DST;
               cnt_d   = '0;
               byte_d  = mac_byte(DST_MAC, 3'd0);
            end
            S_DST:
               if (cnt_q == 11'd5) begin
                  state_d = S_SRC;
                  cnt_d   = '0;
                  byte_d  = mac_byte(BOARD_MAC, 3'd0);
               end else begin
                  byte_d = mac_byte(DST_MAC, cnt_d[2:0]);
               end
            S_SRC:
               if (cnt_q == 11'd5) begin
                  state_d = S_TYPE;
                  cnt_d   = '0;
                  byte_d  = ETH_TYPE[15:8];
               end else begin
                  byte_d = mac_byte(BOARD_MAC, cnt_d[2:0]);
               end
            S_TYPE:
               if (cnt_q == 11'd0) begin
                  byte_d = ETH_TYPE[7:0];
               end else begin
                  cnt_d = '0;
                  if (len_q == 11'd0) begin
                     state_d = S_PAD;
                     byte_d  = 8'h00;
                  end else begin
                     state_d = S_PAYLOAD;
                     byte_d  = tx_data;
                  end
               end
            S_PAYLOAD:
               if (cnt_q == len_last) begin
                  cnt_d = '0;
                  if (len_q < MIN_LEN) begin
                     state_d = S_PAD;
                     byte_d  = 8'h00;
                  end else begin
                     state_d = S_FCS;
                     byte_d  = fcs_byte(crc_upd, 2'd0);
                  end
               end else begin
                  byte_d = tx_data;
               end
            S_PAD:
               if (cnt_q == pad_last) begin
                  state_d = S_FCS;
                  cnt_d   = '0;
                  byte_d  = fcs_byte(crc_upd, 2'd0);
               end else begin
                  byte_d = 8'h00;
               end
            S_FCS:
               if (cnt_q == 11'd3) begin
                  state_d = S_IFG;
                  cnt_d   = '0;
                  byte_d  = 8'h00;
               end else begin
                  byte_d = fcs_byte(crc_q, cnt_d[1:0]);
               end
            S_IFG:
               if (cnt_q == IFG_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            default: state_d = S_IDLE;
         endcase
      end

      // Outputs are registered from the next-cycle view so they line up with
      // the nibble actually being driven in that cycle.
      ctrl_d = !(state_d inside {S_IDLE, S_IFG});
      txd_d  = ctrl_d ? (phase_d ? byte_d[7:4] : byte_d[3:0]) : 4'h0;
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_IFG) && phase_d && (cnt_d == IFG_LAST);
      // Request during phase 0 of the byte before each payload byte.
      req_d  = !phase_d &&
               (((state_d == S_TYPE) && (cnt_d == 11'd1) && (len_q != 11'd0)) ||
                ((state_d == S_PAYLOAD) && (cnt_d != len_last)));
   end

   always_ff @(posedge phy_tx_clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         phase_q <= 1'b0;
         cnt_q   <= '0;
         byte_q  <= '0;
         crc_q   <= '1;
         len_q   <= '0;
         txd_q   <= '0;
         ctrl_q  <= 1'b0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         crc_q   <= crc_d;
         len_q   <= len_d;
         txd_q   <= txd_d;
         ctrl_q  <= ctrl_d;
         req_q   <= req_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign phy_txd     = txd_q;
   assign phy_tx_ctrl = ctrl_q;
   assign tx_data_req = req_q;
   assign tx_done     = done_q;
   assign busy        = busy_q;
   assign status      = state_q;

endmodule

// File: tb/tb_ethernet_transmit.sv
// Testbench for ethernet_transmit: builds each expected frame as a byte list
// from the frame format and checks every output on every cycle of the frame,
// the gap and the first idle cycle after it.
module tb_ethernet_transmit;
   localparam int IFG = 12;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tx_start = 1'b0;
   logic [10:0] tx_len = 11'd0;
   logic [7:0]  tx_data = 8'hee;
   logic        tx_data_req, busy, tx_done, phy_tx_ctrl;
   logic [3:0]  phy_txd;
   logic [9:0]  status;

   always #5 clk = ~clk;

   ethernet_transmit dut (
      .phy_tx_clk  (clk),
      .reset_n     (reset_n),
      .tx_start    (tx_start),
      .tx_len      (tx_len),
      .tx_data     (tx_data),
      .tx_data_req (tx_data_req),
      .busy        (busy),
      .tx_done     (tx_done),
      .phy_txd     (phy_txd),
      .phy_tx_ctrl (phy_tx_ctrl),
      .status      (status)
   );

   int checks = 0;
   int errors = 0;
   int req_count = 0;
   logic [7:0] pay_buf [0:1499];
   logic [7:0] exp_bytes [0:1599];
   int exp_nbytes = 0;
   int exp_len = 0;
   logic [3:0] got_nib [0:3199];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // Non-reflected shift-register CRC fed LSB-first; reversing and inverting
   // the final register gives the IEEE FCS value.
   function automatic logic [31:0] crc_feed(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ 32'h04c11db7;
         else              r = {r[30:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [31:0] fcs_of(input logic [31:0] c);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = c[31 - i];
      return ~r;
   endfunction

   function automatic logic [17:0] dut_vec();
      return {busy, phy_tx_ctrl, tx_done, tx_data_req, phy_txd, status};
   endfunction

   task automatic build_frame(input int len_req);
      logic [47:0] dst_v, src_v;
      logic [15:0] typ_v;
      logic [31:0] c;
      int n, plen;
      dst_v   = 48'hffffffffffff;
      src_v   = 48'h000a3501fec0;
      typ_v   = 16'h0800;
      exp_len = (len_req > 1500) ? 1500 : len_req;
      plen    = (exp_len < 46) ? 46 : exp_len;
      n = 0;
      for (int i = 0; i < 7; i++) begin exp_bytes[n] = 8'h55; n++; end
      exp_bytes[n] = 8'hd5; n++;
      for (int i = 0; i < 6; i++) begin exp_bytes[n] = dst_v[47 - 8*i -: 8]; n++; end
      for (int i = 0; i < 6; i++) begin exp_bytes[n] = src_v[47 - 8*i -: 8]; n++; end
      exp_bytes[n] = typ_v[15:8]; n++;
      exp_bytes[n] = typ_v[7:0];  n++;
      for (int i = 0; i < plen; i++) begin
         exp_bytes[n] = (i < exp_len) ? pay_buf[i] : 8'h00;
         n++;
      end
      c = 32'hffffffff;
      for (int i = 8; i < n; i++) c = crc_feed(c, exp_bytes[i]);
      c = fcs_of(c);
      for (int i = 0; i < 4; i++) begin exp_bytes[n] = c[8*i +: 8]; n++; end
      exp_nbytes = n;
   endtask

   // Expected {busy, ctrl, done, req, txd, status} for cycle k after acceptance.
   function automatic logic [17:0] exp_vec(input int k, input int f_cyc, input int t_cyc);
      int b, idx, plen;
      logic hi, e_busy, e_ctrl, e_done, e_req;
      logic [3:0] nib;
      plen   = (exp_len < 46) ? 46 : exp_len;
      b      = (k - 1) / 2;
      hi     = ((k - 1) % 2) == 1;
      e_busy = (k <= t_cyc);
      e_ctrl = (k <= f_cyc);
      e_done = (k == t_cyc);
      e_req  = 1'b0;
      nib    = 4'h0;
      idx    = 0;
      if (k <= f_cyc) begin
         nib   = hi ? exp_bytes[b][7:4] : exp_bytes[b][3:0];
         e_req = !hi && (b >= 21) && (b <= 20 + exp_len);
         if (b < 7)                 idx = 1;
         else if (b == 7)           idx = 2;
         else if (b < 14)           idx = 3;
         else if (b < 20)           idx = 4;
         else if (b < 22)           idx = 5;
         else if (b < 22 + exp_len) idx = 6;
         else if (b < 22 + plen)    idx = 7;
         else                       idx = 8;
      end else if (k <= t_cyc) begin
         idx = 9;
      end
      return {e_busy, e_ctrl, e_done, e_req, nib, 10'(1) << idx};
   endfunction

   // Upstream FIFO with one cycle of read latency; drives a marker otherwise.
   initial begin
      logic [7:0] v;
      forever begin
         @(negedge clk);
         if (tx_data_req === 1'b1) begin
            v = (req_count < 1500) ? pay_buf[req_count] : 8'hee;
            req_count++;
            @(posedge clk); #1 tx_data = v;
            @(posedge clk); #1 tx_data = 8'hee;
         end
      end
   end

   // Entered at a falling edge with the DUT idle. Pulses tx_start during busy
   // at mid_k and on the tx_done cycle; abort_k > 0 resets mid-frame instead.
   task automatic run_frame(input int len_req, input int mid_k, input int abort_k);
      int f_cyc, t_cyc, bad, n;
      logic [31:0] c, rx_fcs;
      logic [7:0] rx [0:1599];
      build_frame(len_req);
      f_cyc = 2 * exp_nbytes;
      t_cyc = f_cyc + 2 * IFG;
      req_count = 0;
      tx_len = 11'(len_req);
      tx_start = 1'b1;
      for (int k = 1; k <= t_cyc + 1; k++) begin
         @(negedge clk);
         check($sformatf("len%0d_cycle%0d", len_req, k), {14'd0, dut_vec()},
               {14'd0, exp_vec(k, f_cyc, t_cyc)});
         if (k <= f_cyc) got_nib[k - 1] = phy_txd;
         if (k == abort_k) begin
            tx_start = 1'b0;
            reset_n  = 1'b0;
            @(negedge clk);
            check("reset_mid_frame", {14'd0, dut_vec()}, {14'd0, 8'h00, 10'b1});
            reset_n = 1'b1;
            return;
         end
         tx_start = (k == mid_k) || (k == t_cyc);
         tx_len   = 11'd7;
      end
      check($sformatf("len%0d_req_count", len_req), req_count, exp_len);
      n = exp_nbytes;
      for (int b = 0; b < n; b++) rx[b] = {got_nib[2*b + 1], got_nib[2*b]};
      bad = 0;
      for (int j = 0; j < exp_len; j++) if (rx[22 + j] !== pay_buf[j]) bad++;
      check($sformatf("len%0d_rx_payload_bad", len_req), bad, 0);
      c = 32'hffffffff;
      for (int b = 8; b < n - 4; b++) c = crc_feed(c, rx[b]);
      rx_fcs = {rx[n-1], rx[n-2], rx[n-3], rx[n-4]};
      check($sformatf("len%0d_rx_fcs", len_req), rx_fcs, fcs_of(c));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] c;
      for (int i = 0; i < 1500; i++) pay_buf[i] = 8'hee;

      reset_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("reset_hold", {14'd0, dut_vec()}, {14'd0, 8'h00, 10'b1});
      end
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("idle_after_reset", {14'd0, dut_vec()}, {14'd0, 8'h00, 10'b1});
      end

      c = 32'hffffffff;
      for (int i = 0; i < 9; i++) c = crc_feed(c, 8'(8'h31 + i));
      check("crc_model_123456789", fcs_of(c), 32'hcbf43926);

      pay_buf[0] = 8'ha5;
      build_frame(1);
      check("model_len1_cycles", 2 * exp_nbytes, 144);
      check("model_preamble_sfd", {exp_bytes[6], exp_bytes[7]}, 32'h55d5);
      check("model_src_head", {exp_bytes[14], exp_bytes[15]}, 32'h000a);
      check("model_pad_tail", {exp_bytes[22], exp_bytes[67]}, 32'ha500);
      run_frame(1, 40, 0);

      for (int i = 0; i < 64; i++) pay_buf[i] = 8'(i);
      build_frame(64);
      check("model_len64_cycles", 2 * exp_nbytes, 180);
      run_frame(64, 30, 0);

      run_frame(0, 100, 0);

      for (int i = 0; i < 46; i++) pay_buf[i] = 8'(i) ^ 8'h5a;
      run_frame(46, 0, 0);
      run_frame(45, 0, 0);

      for (int i = 0; i < 1500; i++) pay_buf[i] = 8'(i * 7 + 3);
      build_frame(2000);
      check("model_len2000_cycles", 2 * exp_nbytes, 3052);
      run_frame(2000, 1000, 0);

      for (int i = 0; i < 100; i++) pay_buf[i] = 8'(8'hc0 + i);
      run_frame(100, 0, 65);
      repeat (8) begin
         @(negedge clk);
         check("idle_after_abort", {14'd0, dut_vec()}, {14'd0, 8'h00, 10'b1});
      end
      for (int i = 0; i < 10; i++) pay_buf[i] = 8'(8'h90 + i);
      run_frame(10, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
